cordic_vec: RTL
===============

Name: cordic_vec

Overview:
- Vectoring-mode CORDIC: the inverse of the rotation-mode cordic/NCO path.
- Takes one signed I/Q sample (cos, sin) per clock and returns its phase in the same 32-bit turn format the phase accumulator produces, plus its magnitude.
- Also returns the phase increment between consecutive valid samples, which recovers p_inc from an NCO stream.
- Used for loopback checking of the NCO lanes and as the phase/frequency detector in the receive path.

Parameters:
- DATA_W, 16: width of signed sin_i/cos_i.
- PHASE_W, 32: phase width; 2^PHASE_W LSB equals one full turn (2π).
- STAGES, 16: number of CORDIC micro-rotations, 1..PHASE_W-2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-low reset.
- valid_i  in  1  sample qualifier; may have arbitrary gaps.
- cos_i  in  DATA_W  I component, signed two's complement.
- sin_i  in  DATA_W  Q component, signed two's complement.
- valid_o  out  1  phase_o/mag_o are valid this cycle.
- phase_o  out  PHASE_W  atan2(sin,cos) in turns, unsigned, wraps modulo 2^PHASE_W.
- mag_o  out  DATA_W+1  sqrt(cos²+sin²)·K, unsigned, where K≈1.646760 is the CORDIC gain (not compensated).
- freq_o  out  PHASE_W  phase_o minus the previous valid phase_o, modulo 2^PHASE_W.
- freq_valid_o  out  1  freq_o is valid (valid_o AND a previous sample exists).

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous, active-low, and sampled on rising clk_i.
  - While rst_i=0: valid_o, freq_valid_o, phase_o, mag_o and freq_o are all 0; the valid shift register and have_prev are cleared.
  - Datapath registers need no reset.
- Flow control:
  - No backpressure. The pipeline advances every cycle and valid_i travels in a parallel shift register.
  - Gaps in valid_i produce identical gaps in valid_o.
- Latency: STAGES+2 cycles from valid_i to valid_o (18 at default).
  - Stage P: pre-rotation.
  - Stages 0..STAGES-1: micro-rotations.
  - Stage O: output register.
- Internal widths: x/y are DATA_W+3 signed; z is PHASE_W.
- Stage P:
  - Sign-extend the inputs.
  - If cos_i<0: x=-cos, y=-sin, z=2^(PHASE_W-1) (180°). Otherwise x=cos, y=sin, z=0.
  - Negating -2^(DATA_W-1) must not overflow; the extension handles this.
  - Carry a zero flag, set when cos_i==0 and sin_i==0.
- Stage i:
  - If y<0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-A[i].
  - Otherwise: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+A[i].
  - A[i]=round(atan(2^-i)/(2π)·2^PHASE_W); A[0]=0x2000_0000.
  - The zero flag travels unchanged.
- Stage O:
  - phase_o=z, or 0 if the zero flag is set.
  - mag_o=x[DATA_W:0]; x is non-negative after stage P.
  - Zero input therefore gives phase_o=0, mag_o=0.
- freq_o / freq_valid_o:
  - On each valid stage-O output: freq_o=phase_new-last_phase (modulo 2^PHASE_W), then last_phase<=phase_new.
  - freq_valid_o=1 only if have_prev=1; the first valid output after reset sets have_prev and gives freq_valid_o=0.
  - Non-valid cycles leave last_phase and have_prev unchanged, so the difference spans the gap between valid samples.
  - Wrap-around is natural modular subtraction, e.g. 0xF000_0000 → 0x1000_0000 gives 0x2000_0000.
- Reset mid-stream: in-flight samples are discarded. No valid_o occurs until a new valid_i plus latency. have_prev restarts.
- Accuracy at defaults, for |(cos,sin)| ≥ 1024:
  - |phase error| ≤ 2^18 LSB (~3.8e-4 rad).
  - |mag error| ≤ 4 LSB versus ideal·K.

Decomposition:
- Package sdr_pkg holds:
  - DATA_W/PHASE_W defaults;
  - the ATAN_LUT constant array (PHASE_W-bit entries, index 0..PHASE_W-1);
  - CORDIC_K and PHASE_HALF constants.
- The cordic module uses the same package.
- One sub-module, cordic_vec_stage (parameter I, one registered micro-rotation), generated STAGES times; pre-rotation and output/frequency logic stay in the top level.

Test Plan:
- cos=16384, sin=0, single valid → after 18 cycles valid_o=1, phase_o≈0x0000_0000, mag_o≈26981; freq_valid_o=0.
- Quadrant sweep (0,16384), (-16384,0), (0,-16384) back-to-back → phase_o≈0x4000_0000, 0x8000_0000, 0xC000_0000 on consecutive cycles; freq_o≈0x4000_0000 on each with freq_valid_o=1.
- Corner (-32768,-32768) → phase_o≈0xA000_0000, mag_o≈76312 with no overflow; (0,0) → phase_o=0, mag_o=0.
- Feed the cordic NCO output driven with inc 0x3333_3333 (16-bit sin/cos) continuously → from the second valid_o onward, freq_o=0x3333_3333±2^18 every cycle.
- Same NCO stream with valid_i toggled 1,0,0,1 → freq_o≈0x9999_9999 (3·inc mod 2^32) on the output after the gap; valid_o gap pattern matches the input.
- Assert rst_i=0 for 1 cycle while 10 samples are in flight → outputs 0 next cycle, no valid_o for those samples, first post-reset valid_o has freq_valid_o=0.

Source files
------------

// File: rtl/sdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdr_pkg
//  Brief    : Shared SDR constants: default widths, CORDIC arctangent table,
//             CORDIC gain and half-turn phase constant.
//  Revision : 1.0
// ============================================================================
package sdr_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int PHASE_W_DEF = 32;

    localparam logic [31:0] PHASE_HALF = 32'h8000_0000;

    // CORDIC gain K ~= 1.646760 as unsigned Q16.16
    localparam int CORDIC_K_Q16 = 107922;

    // round(atan(2^-i) / (2*pi) * 2^32)
    localparam logic [31:0] ATAN_LUT [0:31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    function automatic logic [31:0] atan_entry(input int i);
        return (i >= 0 && i < 32) ? ATAN_LUT[i] : 32'h0000_0000;
    endfunction

endpackage : sdr_pkg
`default_nettype wire

// File: rtl/cordic_vec_if.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vec_if
//  Brief    : Sample-in / phase-magnitude-frequency-out bundle of cordic_vec.
//  Revision : 1.0
// ============================================================================
interface cordic_vec_if #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 32
);
    logic                      valid_i;
    logic signed [DATA_W-1:0]  cos_i;
    logic signed [DATA_W-1:0]  sin_i;
    logic                      valid_o;
    logic [PHASE_W-1:0]        phase_o;
    logic [DATA_W:0]           mag_o;
    logic [PHASE_W-1:0]        freq_o;
    logic                      freq_valid_o;

    modport master (
        output valid_i, cos_i, sin_i,
        input  valid_o, phase_o, mag_o, freq_o, freq_valid_o
    );

    modport slave (
        input  valid_i, cos_i, sin_i,
        output valid_o, phase_o, mag_o, freq_o, freq_valid_o
    );
endinterface : cordic_vec_if
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vec_stage
//  Brief    : One registered vectoring micro-rotation driving y toward zero.
//  Revision : 1.0
// ============================================================================
module cordic_vec_stage
    import sdr_pkg::*;
#(
    parameter int I       = 0,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  wire logic                      clk,
    input  wire logic signed [DATA_W+2:0]  i_x,
    input  wire logic signed [DATA_W+2:0]  i_y,
    input  wire logic [PHASE_W-1:0]        i_z,
    input  wire logic                      i_zero,
    output logic signed [DATA_W+2:0]       o_x,
    output logic signed [DATA_W+2:0]       o_y,
    output logic [PHASE_W-1:0]             o_z,
    output logic                           o_zero
);

    localparam logic [31:0]        c_angle_full = atan_entry(I);
    localparam logic [PHASE_W-1:0] c_angle      = c_angle_full[31 -: PHASE_W];

    logic signed [DATA_W+2:0] w_x_sh;
    logic signed [DATA_W+2:0] w_y_sh;
    logic signed [DATA_W+2:0] r_x;
    logic signed [DATA_W+2:0] r_y;
    logic [PHASE_W-1:0]       r_z;
    logic                     r_zero;

    assign w_x_sh = i_x >>> I;
    assign w_y_sh = i_y >>> I;

    // Rotate toward the x axis; z accumulates the angle travelled
    always_ff @(posedge clk) begin
        if (i_y[DATA_W+2]) begin
            r_x <= i_x - w_y_sh;
            r_y <= i_y + w_x_sh;
            r_z <= i_z - c_angle;
        end else begin
            r_x <= i_x + w_y_sh;
            r_y <= i_y - w_x_sh;
            r_z <= i_z + c_angle;
        end
        r_zero <= i_zero;
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_z    = r_z;
    assign o_zero = r_zero;

endmodule : cordic_vec_stage
`default_nettype wire

// File: rtl/cordic_vec.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vec
//  Brief    : Pipelined vectoring CORDIC returning phase (turns), magnitude
//             and phase increment between consecutive valid samples.
//  Revision : 1.0
// ============================================================================
module cordic_vec
    import sdr_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int STAGES  = 16
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    cordic_vec_if.slave  bus
);

    localparam int                 c_xw   = DATA_W + 3;
    localparam logic [PHASE_W-1:0] c_half = {1'b1, {(PHASE_W-1){1'b0}}};

    logic signed [c_xw-1:0] w_cos_ext;
    logic signed [c_xw-1:0] w_sin_ext;
    logic signed [c_xw-1:0] r_pre_x;
    logic signed [c_xw-1:0] r_pre_y;
    logic [PHASE_W-1:0]     r_pre_z;
    logic                   r_pre_zero;

    logic signed [c_xw-1:0] w_x    [0:STAGES];
    logic signed [c_xw-1:0] w_y    [0:STAGES];
    logic [PHASE_W-1:0]     w_z    [0:STAGES];
    logic                   w_zero [0:STAGES];

    logic [STAGES:0]        r_valid_sr;
    logic [PHASE_W-1:0]     w_phase_new;
    logic [PHASE_W-1:0]     w_freq_new;
    logic [PHASE_W-1:0]     r_last_phase;
    logic                   r_have_prev;
    logic                   r_valid_o;
    logic [PHASE_W-1:0]     r_phase_o;
    logic [DATA_W:0]        r_mag_o;
    logic [PHASE_W-1:0]     r_freq_o;
    logic                   r_freq_valid_o;

    // Three guard bits keep -(-2^(DATA_W-1)) and the CORDIC gain in range
    assign w_cos_ext = {{3{bus.cos_i[DATA_W-1]}}, bus.cos_i};
    assign w_sin_ext = {{3{bus.sin_i[DATA_W-1]}}, bus.sin_i};

    always_ff @(posedge clk_i) begin
        if (bus.cos_i[DATA_W-1]) begin
            r_pre_x <= -w_cos_ext;
            r_pre_y <= -w_sin_ext;
            r_pre_z <= c_half;
        end else begin
            r_pre_x <= w_cos_ext;
            r_pre_y <= w_sin_ext;
            r_pre_z <= '0;
        end
        r_pre_zero <= (bus.cos_i == '0) && (bus.sin_i == '0);
    end

    assign w_x[0]    = r_pre_x;
    assign w_y[0]    = r_pre_y;
    assign w_z[0]    = r_pre_z;
    assign w_zero[0] = r_pre_zero;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            cordic_vec_stage #(
                .I       (gi),
                .DATA_W  (DATA_W),
                .PHASE_W (PHASE_W)
            ) u_stage (
                .clk    (clk_i),
                .i_x    (w_x[gi]),
                .i_y    (w_y[gi]),
                .i_z    (w_z[gi]),
                .i_zero (w_zero[gi]),
                .o_x    (w_x[gi+1]),
                .o_y    (w_y[gi+1]),
                .o_z    (w_z[gi+1]),
                .o_zero (w_zero[gi+1])
            );
        end
    endgenerate

    // Bit k tracks the sample held in pipeline register k (0 = pre-rotation)
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid_sr <= '0;
        end else begin
            r_valid_sr <= {r_valid_sr[STAGES-1:0], bus.valid_i};
        end
    end

    assign w_phase_new = w_zero[STAGES] ? '0 : w_z[STAGES];
    assign w_freq_new  = w_phase_new - r_last_phase;

    // Only valid outputs advance the frequency reference, so gaps are spanned
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid_o      <= 1'b0;
            r_phase_o      <= '0;
            r_mag_o        <= '0;
            r_freq_o       <= '0;
            r_freq_valid_o <= 1'b0;
            r_last_phase   <= '0;
            r_have_prev    <= 1'b0;
        end else begin
            r_valid_o      <= r_valid_sr[STAGES];
            r_phase_o      <= w_phase_new;
            r_mag_o        <= w_x[STAGES][DATA_W:0];
            r_freq_o       <= w_freq_new;
            r_freq_valid_o <= r_valid_sr[STAGES] & r_have_prev;
            if (r_valid_sr[STAGES]) begin
                r_last_phase <= w_phase_new;
                r_have_prev  <= 1'b1;
            end
        end
    end

    assign bus.valid_o      = r_valid_o;
    assign bus.phase_o      = r_phase_o;
    assign bus.mag_o        = r_mag_o;
    assign bus.freq_o       = r_freq_o;
    assign bus.freq_valid_o = r_freq_valid_o;

endmodule : cordic_vec
`default_nettype wire
